// File: rtl/rf_debug_access.sv
// rf_debug_access
//   Debug-side initiator for the register file. Accepts single-register
//   read/write requests and whole-file dump requests on a valid/ready
//   request channel while the core is halted, drives one RF read port and
//   the RF write port, and returns results on a valid/ready response channel.
//
// Build option:
//   RF_DEBUG_DUMP_EN  defined: op 2'b10 dumps the register file, one beat
//                     per register. Undefined: the dump path is not built
//                     and op 2'b10 is rejected like op 2'b11.
//
// Parameters:
//   XLEN          register data width
//   DUMP_SKIP_X0  1: dump covers x1..x31, 0: dump covers x0..x31
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_core_halted                 requests accepted only while high
//   i_req_* / o_req_ready         request channel (op 00 rd, 01 wr, 10 dump, 11 illegal)
//   o_rsp_* / i_rsp_ready         response channel (addr, data, err, last)
//   o_busy                        transaction in flight
//   o_rf_raddr / i_rf_rdata       RF read port (combinational read data)
//   o_rf_wen/o_rf_waddr/o_rf_wdata RF write port
module rf_debug_access #(
  parameter int unsigned XLEN         = 32,
  parameter bit          DUMP_SKIP_X0 = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_core_halted,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_req_op,
  input  logic [4:0]      i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [4:0]      o_rsp_addr,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_err,
  output logic            o_rsp_last,
  output logic            o_busy,
  output logic [4:0]      o_rf_raddr,
  input  logic [XLEN-1:0] i_rf_rdata,
  output logic            o_rf_wen,
  output logic [4:0]      o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata
);

`ifdef RF_DEBUG_DUMP_EN
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RESP, S_DUMP} state_e;
  localparam logic [4:0] DUMP_FIRST = DUMP_SKIP_X0 ? 5'd1 : 5'd0;
`else
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;
`endif

  state_e            state_q, state_d;
  logic [4:0]        addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [4:0]        rsp_addr_q, rsp_addr_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_last_q, rsp_last_d;
`ifdef RF_DEBUG_DUMP_EN
  logic              dump_q, dump_d;
  logic [4:0]        idx_q, idx_d;
`endif
  logic              accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_last_q <= 1'b0;
`ifdef RF_DEBUG_DUMP_EN
      dump_q     <= 1'b0;
      idx_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_last_q <= rsp_last_d;
`ifdef RF_DEBUG_DUMP_EN
      dump_q     <= dump_d;
      idx_q      <= idx_d;
`endif
    end
  end

  // Ready is forced low during reset so every output reads 0 while i_rst is high.
  assign accept = (state_q == S_IDLE) && i_core_halted && i_req_valid && !i_rst;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_last_d = rsp_last_q;
`ifdef RF_DEBUG_DUMP_EN
    dump_d     = dump_q;
    idx_d      = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d     = i_req_addr;
          wdata_d    = i_req_wdata;
          rsp_addr_d = i_req_addr;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          rsp_last_d = 1'b1;
`ifdef RF_DEBUG_DUMP_EN
          dump_d     = 1'b0;
`endif
          case (i_req_op)
            2'b00: state_d = S_RD;
            2'b01: begin
              if (i_req_addr == '0) begin
                rsp_err_d = 1'b1;
                state_d   = S_RESP;
              end else begin
                state_d   = S_WR;
              end
            end
`ifdef RF_DEBUG_DUMP_EN
            2'b10: begin
              dump_d  = 1'b1;
              idx_d   = DUMP_FIRST;
              state_d = S_DUMP;
            end
`endif
            default: begin
              rsp_err_d = 1'b1;
              state_d   = S_RESP;
            end
          endcase
        end
      end
      S_RD: begin
        rsp_data_d = i_rf_rdata;
        state_d    = S_RESP;
      end
      S_WR: begin
        rsp_data_d = wdata_q;
        state_d    = S_RESP;
      end
`ifdef RF_DEBUG_DUMP_EN
      S_DUMP: begin
        rsp_addr_d = idx_q;
        rsp_data_d = i_rf_rdata;
        rsp_err_d  = 1'b0;
        rsp_last_d = (idx_q == 5'd31);
        state_d    = S_RESP;
      end
`endif
      S_RESP: begin
        if (i_rsp_ready) begin
`ifdef RF_DEBUG_DUMP_EN
          if (dump_q && !rsp_last_q) begin
            idx_d   = idx_q + 5'd1;
            state_d = S_DUMP;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (state_q == S_IDLE) && i_core_halted && !i_rst;
    o_rsp_valid = (state_q == S_RESP);
    o_rsp_addr  = rsp_addr_q;
    o_rsp_data  = rsp_data_q;
    o_rsp_err   = rsp_err_q;
    o_rsp_last  = rsp_last_q;
    o_busy      = (state_q != S_IDLE);
    o_rf_raddr  = '0;
    if (state_q == S_RD) o_rf_raddr = addr_q;
`ifdef RF_DEBUG_DUMP_EN
    if (state_q == S_DUMP) o_rf_raddr = idx_q;
`endif
    // x0 never reaches WR; the address term is a second guard on the write port.
    o_rf_wen    = (state_q == S_WR) && (addr_q != '0);
    o_rf_waddr  = addr_q;
    o_rf_wdata  = wdata_q;
  end

endmodule
